// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and
// parameter legality checks used by both receive and transmit engines.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic bit data_bits_ok(input int n);
    return (n >= 5) && (n <= 9);
  endfunction

  function automatic bit oversample_ok(input int n);
    return (n >= 8) && ((n % 2) == 0);
  endfunction

  function automatic bit stop_bits_ok(input int n);
    return (n == 1) || (n == 2);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser, falling-edge detect and a
// 3-sample majority voter resolved against the live synchronised sample.
module uart_rx_sampler (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  input  logic smp_i,
  output logic rx_s_o,
  output logic fall_o,
  output logic bit_val_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic [1:0] smp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      smp_q  <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= sync_q[1];
      if (smp_i) begin
        smp_q <= {smp_q[0], sync_q[1]};
      end
    end
  end

  assign rx_s_o = sync_q[1];
  assign fall_o = prev_q & ~sync_q[1];

  // third vote is the sample taken on the resolving tick itself
  assign bit_val_o = (smp_q[1] & smp_q[0])
                   | (smp_q[1] & sync_q[1])
                   | (smp_q[0] & sync_q[1]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: N data bits, optional parity, 1/2 stop bits,
// majority-voted sampling, false-start rejection and break detection.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  input  logic                 s_tick_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 parity_err_o,
  output logic                 framing_err_o,
  output logic                 break_det_o,
  output logic                 busy_o
);

  import uart_pkg::*;

  if (!data_bits_ok(DATA_BITS) || !oversample_ok(OVERSAMPLE)
      || !stop_bits_ok(STOP_BITS)) begin : g_bad_cfg
    $error("uart_rx_cfg: illegal parameter set");
  end

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] C_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_SMP  = CW'(OVERSAMPLE - 3);
  localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DB_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SB_LAST = 4'(STOP_BITS - 1);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 stop_q, stop_d;
  logic                 brk_q, brk_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  logic rx_s, fall, bit_val;
  logic in_bit, smp, last;

  assign in_bit = (state_q == ST_DATA) || (state_q == ST_PARITY)
               || (state_q == ST_STOP);
  assign smp    = s_tick_i && in_bit && (cnt_q >= C_SMP);
  assign last   = s_tick_i && (cnt_q == C_LAST);

  uart_rx_sampler u_smp (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx_i),
    .smp_i     (smp),
    .rx_s_o    (rx_s),
    .fall_o    (fall),
    .bit_val_o (bit_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      brk_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      brk_q   <= brk_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    stop_d  = stop_q;
    brk_d   = brk_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;

    if (in_bit && s_tick_i) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (s_tick_i) begin
          if (cnt_q == C_HALF) begin
            state_d = rx_s ? ST_IDLE : ST_DATA;
            cnt_d   = '0;
            bit_d   = '0;
            par_d   = 1'b0;
            stop_d  = 1'b0;
            brk_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (last) begin
          sh_d = {bit_val, sh_q[DATA_BITS-1:1]};
          if (bit_q == DB_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (last) begin
          par_d   = (^sh_q) ^ bit_val ^ PAR_MODE;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (last) begin
          stop_d = stop_q | ~bit_val;
          if ((bit_q == '0) && !bit_val && (sh_q == '0)) begin
            brk_d = 1'b1;
          end
          if (bit_q == SB_LAST) begin
            state_d = ST_DONE;
            data_d  = sh_q;
            perr_d  = par_q;
            ferr_d  = stop_d;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        // a start edge landing here is taken directly so back-to-back
        // frames are not lost
        state_d = fall ? ST_START : ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rx_data_o     = data_q;
  assign rx_valid_o    = (state_q == ST_DONE);
  assign parity_err_o  = perr_q;
  assign framing_err_o = ferr_q;
  assign break_det_o   = (state_q == ST_DONE) && brk_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 7E1 and 8N2 instances driven
// by hand-built frames with hand-computed expectations.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_tick = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic rx2 = 1'b1;

  logic [7:0] d0, d2;
  logic [6:0] d1;
  logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2;
  logic bk0, bk1, bk2, by0, by1, by2;

  always #5 clk = ~clk;

  uart_rx_cfg u0 (
    .clk(clk), .rst(rst), .rx_i(rx0), .s_tick_i(s_tick),
    .rx_data_o(d0), .rx_valid_o(v0), .parity_err_o(pe0),
    .framing_err_o(fe0), .break_det_o(bk0), .busy_o(by0)
  );

  uart_rx_cfg #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst(rst), .rx_i(rx1), .s_tick_i(s_tick),
    .rx_data_o(d1), .rx_valid_o(v1), .parity_err_o(pe1),
    .framing_err_o(fe1), .break_det_o(bk1), .busy_o(by1)
  );

  uart_rx_cfg #(.STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .rx_i(rx2), .s_tick_i(s_tick),
    .rx_data_o(d2), .rx_valid_o(v2), .parity_err_o(pe2),
    .framing_err_o(fe2), .break_det_o(bk2), .busy_o(by2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int vcnt[3];
  int bcnt[3];
  int vcyc[3];
  logic [7:0] cdat[3];
  logic cpe[3], cfe[3], cbk[3];

  task automatic rec(input int i, input logic [7:0] d,
                     input logic pe, input logic fe, input logic bk);
    vcnt[i]++;
    vcyc[i] = cyc;
    cdat[i] = d;
    cpe[i] = pe;
    cfe[i] = fe;
    cbk[i] = bk;
  endtask

  always @(negedge clk) begin
    if (v0) rec(0, d0, pe0, fe0, bk0);
    if (v1) rec(1, {1'b0, d1}, pe1, fe1, bk1);
    if (v2) rec(2, d2, pe2, fe2, bk2);
    if (bk0) bcnt[0]++;
    if (bk1) bcnt[1]++;
    if (bk2) bcnt[2]++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int i, input logic b);
    case (i)
      0: rx0 = b;
      1: rx1 = b;
      default: rx2 = b;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // frame bits LSB first, 16 clk per bit; line released high afterwards
  task automatic send(input int i, input logic [15:0] f, input int n);
    for (int k = 0; k < n; k++) begin
      set_rx(i, f[k]);
      idle(16);
    end
    set_rx(i, 1'b1);
  endtask

  function automatic logic [15:0] fr8(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  function automatic logic [15:0] fr8s2(input logic [7:0] d,
                                        input logic s2);
    return {5'b0, s2, 1'b1, d, 1'b0};
  endfunction

  function automatic logic [15:0] fr7p(input logic [6:0] d,
                                       input logic p);
    return {6'b0, 1'b1, p, d, 1'b0};
  endfunction

  int t0;
  int nv;
  int nb;

  initial begin
    idle(2);
    chk("rst_valid", v0, 0);
    chk("rst_busy", by0, 0);
    chk("rst_data", d0, 0);
    chk("rst_perr", pe1, 0);
    chk("rst_ferr", fe0, 0);
    chk("rst_brk", bk0, 0);
    rst = 1'b0;
    idle(4);

    // 8N1 0xA5; latency = 3 (sync+edge) + 8 (half start) + 16*9
    t0 = cyc;
    send(0, fr8(8'hA5), 10);
    idle(4);
    chk("a5_cnt", vcnt[0], 1);
    chk("a5_data", cdat[0], 8'hA5);
    chk("a5_perr", cpe[0], 0);
    chk("a5_ferr", cfe[0], 0);
    chk("a5_brk", cbk[0], 0);
    chk("a5_lat", vcyc[0] - t0, 155);
    chk("a5_busy", by0, 0);

    // reset during data bit 4
    nv = vcnt[0];
    send(0, fr8(8'hFF), 5);
    idle(8);
    chk("mid_busy_pre", by0, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mid_busy", by0, 0);
    chk("mid_valid", v0, 0);
    chk("mid_data", d0, 0);
    idle(200);
    chk("mid_novalid", vcnt[0], nv);
    t0 = cyc;
    send(0, fr8(8'h81), 10);
    idle(4);
    chk("x81_cnt", vcnt[0], nv + 1);
    chk("x81_data", cdat[0], 8'h81);
    chk("x81_lat", vcyc[0] - t0, 155);

    // 7E1: 0x41 has two ones -> even parity bit 0
    t0 = cyc;
    send(1, fr7p(7'h41, 1'b0), 10);
    idle(4);
    chk("p0_cnt", vcnt[1], 1);
    chk("p0_data", cdat[1], 8'h41);
    chk("p0_perr", cpe[1], 0);
    chk("p0_lat", vcyc[1] - t0, 155);
    send(1, fr7p(7'h41, 1'b1), 10);
    idle(4);
    chk("p1_cnt", vcnt[1], 2);
    chk("p1_perr", cpe[1], 1);
    chk("p1_ferr", cfe[1], 0);
    idle(20);
    chk("p1_hold", pe1, 1);
    send(1, fr7p(7'h07, 1'b1), 10);
    idle(4);
    chk("p2_perr", cpe[1], 0);
    chk("p2_data", cdat[1], 8'h07);

    // stop bit low
    nv = vcnt[0];
    send(0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10);
    idle(32);
    chk("fe_cnt", vcnt[0], nv + 1);
    chk("fe_data", cdat[0], 8'h3C);
    chk("fe_ferr", cfe[0], 1);
    chk("fe_brk", cbk[0], 0);
    chk("fe_hold", fe0, 1);

    // break: line low for two frame times
    nv = vcnt[0];
    nb = bcnt[0];
    rx0 = 1'b0;
    idle(320);
    chk("brk_pulses", bcnt[0], nb + 1);
    chk("brk_cnt", vcnt[0], nv + 1);
    chk("brk_data", cdat[0], 0);
    chk("brk_ferr", cfe[0], 1);
    chk("brk_busy_low", by0, 0);
    rx0 = 1'b1;
    idle(40);
    chk("brk_noretrig", vcnt[0], nv + 1);
    chk("brk_once", bcnt[0], nb + 1);

    // short low glitch on idle line
    nv = vcnt[0];
    rx0 = 1'b0;
    idle(3);
    rx0 = 1'b1;
    chk("gl_busy", by0, 1);
    idle(40);
    chk("gl_novalid", vcnt[0], nv);
    chk("gl_idle", by0, 0);

    // 0x00 with a one-clk high pulse on the resolving sample of bit 3
    rx0 = 1'b0;
    idle(72);
    rx0 = 1'b1;
    idle(1);
    rx0 = 1'b0;
    idle(71);
    rx0 = 1'b1;
    idle(16);
    idle(4);
    chk("mj_cnt", vcnt[0], nv + 1);
    chk("mj_data", cdat[0], 8'h00);
    chk("mj_ferr", cfe[0], 0);

    // 8N2 back-to-back
    send(2, fr8s2(8'h55, 1'b1), 11);
    chk("bb1_cnt", vcnt[2], 1);
    chk("bb1_data", cdat[2], 8'h55);
    t0 = cyc;
    send(2, fr8s2(8'hAA, 1'b1), 11);
    idle(4);
    chk("bb2_cnt", vcnt[2], 2);
    chk("bb2_data", cdat[2], 8'hAA);
    chk("bb2_ferr", cfe[2], 0);
    chk("bb2_lat", vcyc[2] - t0, 171);

    // second stop bit low on one frame only
    send(2, fr8s2(8'h55, 1'b0), 11);
    idle(32);
    chk("s2_cnt", vcnt[2], 3);
    chk("s2_ferr", cfe[2], 1);
    chk("s2_hold", fe2, 1);
    send(2, fr8s2(8'hAA, 1'b1), 11);
    idle(4);
    chk("s2n_cnt", vcnt[2], 4);
    chk("s2n_ferr", cfe[2], 0);
    chk("s2n_data", cdat[2], 8'hAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
